decim_sched: RTL

- Central rate controller and output serializer for the per-channel PDM decimation chain (CIC -> HalfBand1 -> HalfBand2 -> F_FIR).
- Replaces the cascaded clock dividers with single-clock stage strobes derived from one counter.
- On every FIR-rate strobe, snapshots all channel FIR outputs and streams them out one channel per beat over a valid/ready interface.
- Flags any frame that arrives while the previous frame is still draining.

---
 rtl/decim_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/decim_sched.sv
// decim_sched: single-clock CIC/HB1/HB2/FIR rate strobes and a per-frame channel serializer.
// Optional macro DECIM_FRAME_CNT_EN adds a 16-bit frame number (m_frame) to every beat.
module decim_sched #(
    parameter int  NCH     = 20,
    parameter int  DW      = 16,
    parameter int  CIC_DIV = 8,
    localparam int CW      = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              cic_stb,
    output logic              hb1_stb,
    output logic              hb2_stb,
    output logic              fir_stb,
    input  logic [NCH*DW-1:0] fir_data,
    output logic [DW-1:0]     m_data,
    output logic [CW-1:0]     m_chan,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              ovf,
    input  logic              ovf_clr
`ifdef DECIM_FRAME_CNT_EN
    ,
    output logic [15:0]       m_frame
`endif
);

    localparam int              DIVW     = (CIC_DIV > 1) ? $clog2(CIC_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CIC_DIV - 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(NCH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [DIVW-1:0]   div_cnt_r;
    logic [2:0]        stage_r;
    logic              cic_stb_r, hb1_stb_r, hb2_stb_r, fir_stb_r;
    logic              tick_s;

    state_t            state_r, state_s;
    logic [CW-1:0]     idx_r, idx_s;
    logic [NCH*DW-1:0] shadow_r, shadow_s;
    logic [DW-1:0]     m_data_r, m_data_s;
    logic [CW-1:0]     m_chan_r, m_chan_s;
    logic              m_last_r, m_last_s;
    logic              m_valid_r, m_valid_s;
    logic              ovf_r, ovf_s;
    logic              hs_s, load_s, overrun_s;

    // Terminal count of the CIC divider while running.
    always_comb begin
        tick_s = en && (div_cnt_r == DIV_LAST);
    end

    // Rate counter, stage counter and registered stage strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r <= {DIVW{1'b0}};
            stage_r   <= 3'd0;
            cic_stb_r <= 1'b0;
            hb1_stb_r <= 1'b0;
            hb2_stb_r <= 1'b0;
            fir_stb_r <= 1'b0;
        end else begin
            if (en) begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_r <= {DIVW{1'b0}};
                end else begin
                    div_cnt_r <= div_cnt_r + DIVW'(1'b1);
                end
            end
            // stage already holds the value seen during the upcoming strobe cycle
            if (cic_stb_r) begin
                stage_r <= stage_r + 3'd1;
            end
            cic_stb_r <= tick_s;
            hb1_stb_r <= tick_s & stage_r[0];
            hb2_stb_r <= tick_s & (stage_r[1:0] == 2'b11);
            fir_stb_r <= tick_s & (stage_r == 3'b111);
        end
    end

    // Serializer next-state: capture, beat advance, overrun detection.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        shadow_s  = shadow_r;
        m_data_s  = m_data_r;
        m_chan_s  = m_chan_r;
        m_last_s  = m_last_r;
        m_valid_s = m_valid_r;
        load_s    = 1'b0;
        overrun_s = 1'b0;
        hs_s      = m_valid_r & m_ready;
        case (state_r)
            ST_IDLE: begin
                m_valid_s = 1'b0;
                load_s    = fir_stb_r;
            end
            ST_SEND: begin
                if (hs_s) begin
                    if (idx_r == LAST_IDX) begin
                        if (fir_stb_r) begin
                            load_s = 1'b1;
                        end else begin
                            state_s   = ST_IDLE;
                            m_valid_s = 1'b0;
                        end
                    end else begin
                        idx_s    = idx_r + CW'(1'b1);
                        m_data_s = shadow_r[idx_s*DW +: DW];
                        m_chan_s = idx_s;
                        m_last_s = (idx_s == LAST_IDX);
                    end
                end else begin
                    idx_s = idx_r;
                end
                overrun_s = fir_stb_r & ~load_s;
            end
            default: begin
                state_s   = ST_IDLE;
                m_valid_s = 1'b0;
            end
        endcase
        if (load_s) begin
            state_s   = ST_SEND;
            idx_s     = {CW{1'b0}};
            shadow_s  = fir_data;
            m_valid_s = 1'b1;
            m_data_s  = fir_data[DW-1:0];
            m_chan_s  = {CW{1'b0}};
            m_last_s  = (LAST_IDX == {CW{1'b0}});
        end else begin
            shadow_s = shadow_r;
        end
        // set wins over a same-cycle clear
        ovf_s = overrun_s | (ovf_r & ~ovf_clr);
    end

    // Serializer state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= {CW{1'b0}};
            shadow_r  <= {(NCH*DW){1'b0}};
            m_data_r  <= {DW{1'b0}};
            m_chan_r  <= {CW{1'b0}};
            m_last_r  <= 1'b0;
            m_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            shadow_r  <= shadow_s;
            m_data_r  <= m_data_s;
            m_chan_r  <= m_chan_s;
            m_last_r  <= m_last_s;
            m_valid_r <= m_valid_s;
            ovf_r     <= ovf_s;
        end
    end

`ifdef DECIM_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;
    logic [15:0] m_frame_r;

    // Frame numbering: counts every FIR strobe, captured or dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_r <= 16'd0;
            m_frame_r   <= 16'd0;
        end else begin
            if (fir_stb_r) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            if (load_s) begin
                m_frame_r <= frame_cnt_r;
            end
        end
    end

    assign m_frame = m_frame_r;
`endif

    assign cic_stb = cic_stb_r;
    assign hb1_stb = hb1_stb_r;
    assign hb2_stb = hb2_stb_r;
    assign fir_stb = fir_stb_r;
    assign m_data  = m_data_r;
    assign m_chan  = m_chan_r;
    assign m_last  = m_last_r;
    assign m_valid = m_valid_r;
    assign ovf     = ovf_r;

endmodule
